wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have no parameters; data width SHALL be the shared constant RegW (32).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high. Ports are named clk_i and rst_i.
REQ-003 clk_i  in  1  clock.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 ms_valid_i  in  1  memory stage presents an instruction.
REQ-006 ws_allowin_o  out  1  wb_stage accepts a new instruction this cycle.
REQ-007 ms_pc_i  in  32  PC of the presented instruction.
REQ-008 ms_dest_i  in  5  destination register.
REQ-009 ms_rf_we_i  in  1  the instruction writes the register file.
REQ-010 ms_result_i  in  32  ALU result, or the load address for loads.
REQ-011 ms_ld_op_i  in  3  load type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; values 6 and 7 are treated as none.
REQ-012 dram_rdata_i  in  32  data RAM read word.
REQ-013 dram_rvalid_i  in  1  dram_rdata_i is valid this cycle.
REQ-014 flush_i  in  1  kill the held instruction (exception or branch redirect).
REQ-015 rf_waddr_o  out  5  register file write address.
REQ-016 rf_wdata_o  out  RegW  register file write data.
REQ-017 fwd_valid_o  out  1  forwarding information is meaningful.
REQ-018 fwd_dest_o  out  5  forwarding destination register.
REQ-019 fwd_data_o  out  RegW  forwarding data.
REQ-020 fwd_busy_o  out  1  destination value is not yet available (load still waiting for data).

Function
REQ-021 The stage SHALL hold one pipeline register: valid, pc, dest, rf_we, result, ld_op.
REQ-022 ready_go = !is_load || dram_rvalid_i.
REQ-023 ws_allowin_o = !ws_valid || ready_go.
REQ-024 The stage SHALL capture the ms_* inputs when ms_valid_i && ws_allowin_o; ws_valid SHALL become ms_valid_i whenever ws_allowin_o is high.
REQ-025 State SHALL be IDLE (ws_valid=0), WAIT (valid load, no rvalid) or COMMIT (ready_go=1).
- WAIT persists across cycles with the register contents frozen.
- COMMIT lasts exactly one cycle.
REQ-026 Load alignment: the byte offset is result[1:0].
- LB/LBU select byte 8*offset; LH/LHU select halfword 16*offset[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-027 Unaligned LH/LW (offset[0]=1 for LH, offset≠0 for LW) SHALL use the word as-is, with no trap.
REQ-028 final_data SHALL be the aligned load data for loads, else result.
REQ-029 rf_waddr_o SHALL be dest only in COMMIT with rf_we=1, else 5'd0. The register file has no write enable; address 0 is the discard sink.
REQ-030 rf_wdata_o SHALL equal final_data in COMMIT, else 0.
REQ-031 fwd_valid_o = ws_valid && rf_we && dest≠0.
REQ-032 fwd_dest_o = dest; fwd_data_o = final_data; fwd_busy_o = fwd_valid_o && !ready_go.
REQ-033 flush_i SHALL clear ws_valid next cycle and suppress the write in that cycle, even in COMMIT; an input presented in the same cycle SHALL be dropped.
REQ-034 Back-to-back instructions SHALL sustain one commit per cycle with no bubble.
REQ-035 Latency from capture to register file write SHALL be 1 cycle for non-loads, and 1 + the number of WAIT cycles for loads.

Reset
REQ-036 rst_i SHALL clear ws_valid and all held fields to 0, including mid-WAIT, which drops the load.
REQ-037 While rst_i is asserted, every output SHALL be 0 except ws_allowin_o, which is 1.
REQ-038 The first capture SHALL occur on the first edge after rst_i deasserts.

Configuration
REQ-039 Macro WB_TRACE_EN SHALL add the outputs debug_wb_pc[31:0], debug_wb_rf_we[3:0], debug_wb_rf_wnum[4:0] and debug_wb_rf_wdata[31:0].
- These carry pc, {4{commit write}}, dest and final_data during COMMIT, and are 0 otherwise.
- Without the macro these ports and their logic SHALL be absent and behaviour is otherwise identical.

Structure
REQ-040 RegW, the load-op encodings and the bus widths SHALL live in the shared common header.
REQ-041 Load alignment SHALL be a combinational sub-module ld_align (inputs op, offset, word; output data).

Verification
REQ-042 Non-load: ADD result 0x12345678, dest 5 -> rf_waddr_o=5, rf_wdata_o=0x12345678 one cycle after capture; fwd_busy_o=0.
REQ-043 LB at offset 3, word 0x80FF_0000, rvalid delayed 2 cycles -> ws_allowin_o=0 for 2 cycles, fwd_busy_o=1, then rf_wdata_o=0xFFFFFF80.
REQ-044 LHU at offset 2, word 0xBEEF_1234 -> 0x0000BEEF; LH -> 0xFFFFBEEF.
REQ-045 dest 0 with rf_we=1 -> fwd_valid_o=0, rf_waddr_o=0.
REQ-046 flush_i during WAIT, then rvalid -> no register file write; stage idle the next cycle.
REQ-047 rst_i asserted mid-WAIT -> all outputs 0, ws_allowin_o=1; next instruction commits normally.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the write-back stage.
package wb_stage_pkg;

  localparam int RegW  = 32;
  localparam int PcW   = 32;
  localparam int RegAW = 5;
  localparam int LdOpW = 3;

  typedef enum logic [LdOpW-1:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_H    = 3'd2,
    LD_W    = 3'd3,
    LD_BU   = 3'd4,
    LD_HU   = 3'd5
  } ld_op_e;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT,
    WB_COMMIT
  } wb_state_e;

  // Encodings 6 and 7 are not loads.
  function automatic logic is_load_op(input logic [LdOpW-1:0] op);
    return (op == LD_B)  || (op == LD_H)  || (op == LD_W) ||
           (op == LD_BU) || (op == LD_HU);
  endfunction

endpackage

// File: rtl/wb_stage_ld_align.sv
// Load data alignment and extension for the write-back stage.
module ld_align
  import wb_stage_pkg::*;
(
  input  logic [LdOpW-1:0] op_i,
  input  logic [1:0]       offset_i,
  input  logic [RegW-1:0]  word_i,
  output logic [RegW-1:0]  data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word_i[7:0];
    case (offset_i)
      2'd0: w_byte = word_i[7:0];
      2'd1: w_byte = word_i[15:8];
      2'd2: w_byte = word_i[23:16];
      2'd3: w_byte = word_i[31:24];
      default: w_byte = word_i[7:0];
    endcase
    w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Odd-offset halfwords and all words fall through untouched.
  always_comb begin
    data_o = word_i;
    unique case (1'b1)
      op_i == LD_B:
        data_o = {{24{w_byte[7]}}, w_byte};
      op_i == LD_BU:
        data_o = {24'd0, w_byte};
      (op_i == LD_H) && !offset_i[0]:
        data_o = {{16{w_half[15]}}, w_half};
      (op_i == LD_HU) && !offset_i[0]:
        data_o = {16'd0, w_half};
      default:
        data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage with load alignment and forwarding.
// Define WB_TRACE_EN to add the debug_wb_* commit trace outputs.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ms_valid_i,
  output logic              ws_allowin_o,
  input  logic [PcW-1:0]    ms_pc_i,
  input  logic [RegAW-1:0]  ms_dest_i,
  input  logic              ms_rf_we_i,
  input  logic [RegW-1:0]   ms_result_i,
  input  logic [LdOpW-1:0]  ms_ld_op_i,
  input  logic [RegW-1:0]   dram_rdata_i,
  input  logic              dram_rvalid_i,
  input  logic              flush_i,
  output logic [RegAW-1:0]  rf_waddr_o,
  output logic [RegW-1:0]   rf_wdata_o,
  output logic              fwd_valid_o,
  output logic [RegAW-1:0]  fwd_dest_o,
  output logic [RegW-1:0]   fwd_data_o,
  output logic              fwd_busy_o
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
`endif
);

  logic              r_valid;
  logic [PcW-1:0]    r_pc;
  logic [RegAW-1:0]  r_dest;
  logic              r_rf_we;
  logic [RegW-1:0]   r_result;
  logic [LdOpW-1:0]  r_ld_op;

  logic              w_valid;
  logic              w_is_load;
  logic              w_ready_go;
  logic              w_commit;
  logic [RegW-1:0]   w_ld_data;
  logic [RegW-1:0]   w_final;
  wb_state_e         w_state;

  // Reset masks the stale register contents on the asserting cycle.
  assign w_valid    = r_valid & ~rst_i;
  assign w_is_load  = w_valid && is_load_op(r_ld_op);
  assign w_ready_go = !w_is_load || dram_rvalid_i;

  always_comb begin
    w_state = WB_IDLE;
    if (w_valid)
      w_state = w_ready_go ? WB_COMMIT : WB_WAIT;
  end

  assign w_commit     = (w_state == WB_COMMIT) && !flush_i;
  assign ws_allowin_o = !w_valid || w_ready_go;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_dest   <= '0;
      r_rf_we  <= 1'b0;
      r_result <= '0;
      r_ld_op  <= '0;
    end else if (flush_i) begin
      r_valid  <= 1'b0;
    end else if (ws_allowin_o) begin
      r_valid  <= ms_valid_i;
      if (ms_valid_i) begin
        r_pc     <= ms_pc_i;
        r_dest   <= ms_dest_i;
        r_rf_we  <= ms_rf_we_i;
        r_result <= ms_result_i;
        r_ld_op  <= ms_ld_op_i;
      end
    end
  end

  ld_align u_ld_align (
    .op_i     (r_ld_op),
    .offset_i (r_result[1:0]),
    .word_i   (dram_rdata_i),
    .data_o   (w_ld_data)
  );

  assign w_final = w_is_load ? w_ld_data : r_result;

  assign rf_waddr_o  = (w_commit && r_rf_we) ? r_dest : '0;
  assign rf_wdata_o  = w_commit ? w_final : '0;
  assign fwd_valid_o = w_valid && r_rf_we && (r_dest != '0);
  assign fwd_dest_o  = rst_i ? '0 : r_dest;
  assign fwd_data_o  = rst_i ? '0 : w_final;
  assign fwd_busy_o  = fwd_valid_o && !w_ready_go;

`ifdef WB_TRACE_EN
  assign debug_wb_pc       = w_commit ? r_pc : '0;
  assign debug_wb_rf_we    = {4{w_commit && r_rf_we}};
  assign debug_wb_rf_wnum  = w_commit ? r_dest : '0;
  assign debug_wb_rf_wdata = w_commit ? w_final : '0;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^r_pc;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage with a write scoreboard.
module tb_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ms_valid_i = 1'b0;
  logic        ws_allowin_o;
  logic [31:0] ms_pc_i = '0;
  logic [4:0]  ms_dest_i = '0;
  logic        ms_rf_we_i = 1'b0;
  logic [31:0] ms_result_i = '0;
  logic [2:0]  ms_ld_op_i = '0;
  logic [31:0] dram_rdata_i = '0;
  logic        dram_rvalid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_dest_o;
  logic [31:0] fwd_data_o;
  logic        fwd_busy_o;
`ifdef WB_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [36:0] sb_q[$];

  always #5 clk_i = ~clk_i;

  wb_stage dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ms_valid_i    (ms_valid_i),
    .ws_allowin_o  (ws_allowin_o),
    .ms_pc_i       (ms_pc_i),
    .ms_dest_i     (ms_dest_i),
    .ms_rf_we_i    (ms_rf_we_i),
    .ms_result_i   (ms_result_i),
    .ms_ld_op_i    (ms_ld_op_i),
    .dram_rdata_i  (dram_rdata_i),
    .dram_rvalid_i (dram_rvalid_i),
    .flush_i       (flush_i),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .fwd_valid_o   (fwd_valid_o),
    .fwd_dest_o    (fwd_dest_o),
    .fwd_data_o    (fwd_data_o),
    .fwd_busy_o    (fwd_busy_o)
`ifdef WB_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  // Any visible write pops the oldest expected write.
  always @(negedge clk_i) begin
    logic [36:0] e;
    if (rf_waddr_o != 5'd0 || rf_wdata_o != 32'd0) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected got %0d/%h want none",
                 rf_waddr_o, rf_wdata_o);
      end else begin
        e = sb_q.pop_front();
        if ({rf_waddr_o, rf_wdata_o} !== e) begin
          n_fail++;
          $display("FAIL sb_write got %0d/%h want %0d/%h",
                   rf_waddr_o, rf_wdata_o, e[36:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [2:0] op,
                                           input logic [31:0] res,
                                           input logic [31:0] w);
    int sh;
    logic [31:0] v;
    sh = int'(res[1:0]);
    v = res;
    case (op)
      3'd1, 3'd4: begin
        v = (w >> (8 * sh)) & 32'h0000_00FF;
        if (op == 3'd1 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'd2, 3'd5: begin
        if (sh % 2 == 1) v = w;
        else begin
          v = (w >> (8 * sh)) & 32'h0000_FFFF;
          if (op == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
        end
      end
      3'd3: v = w;
      default: v = res;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic drive(input logic [4:0] d, input logic we,
                       input logic [31:0] res, input logic [2:0] op);
    ms_valid_i  = 1'b1;
    ms_pc_i     = ms_pc_i + 32'd4;
    ms_dest_i   = d;
    ms_rf_we_i  = we;
    ms_result_i = res;
    ms_ld_op_i  = op;
  endtask

  task automatic idle();
    ms_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    sample();
    n_chk++;
    if (ws_allowin_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_allowin got %b want 1", ws_allowin_o);
    end
    n_chk++;
    if ({rf_waddr_o, rf_wdata_o, fwd_valid_o, fwd_dest_o,
         fwd_data_o, fwd_busy_o} !== 76'd0) begin
      n_fail++;
      $display("FAIL rst_outputs got %0d %h %b %0d %h %b want zeros",
               rf_waddr_o, rf_wdata_o, fwd_valid_o, fwd_dest_o,
               fwd_data_o, fwd_busy_o);
    end
    step();
    rst_i = 1'b0;
    drive(5'd2, 1'b1, 32'h0000_0077, 3'd0);
    sb_q.push_back({5'd2, 32'h0000_0077});
    step();
    idle();
    sample();
    n_chk++;
    if ({rf_waddr_o, rf_wdata_o} !== {5'd2, 32'h0000_0077}) begin
      n_fail++;
      $display("FAIL first_capture got %0d/%h want 2/00000077",
               rf_waddr_o, rf_wdata_o);
    end
  endtask

  task automatic test_alu();
    step();
    drive(5'd5, 1'b1, 32'h1234_5678, 3'd0);
    sb_q.push_back({5'd5, 32'h1234_5678});
    step();
    idle();
    sample();
    n_chk++;
    if ({rf_waddr_o, rf_wdata_o} !== {5'd5, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL alu_write got %0d/%h want 5/12345678",
               rf_waddr_o, rf_wdata_o);
    end
    n_chk++;
    if ({fwd_valid_o, fwd_busy_o, fwd_dest_o, fwd_data_o} !==
        {1'b1, 1'b0, 5'd5, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL alu_fwd got v%b b%b %0d %h want v1 b0 5 12345678",
               fwd_valid_o, fwd_busy_o, fwd_dest_o, fwd_data_o);
    end
    step();
    sample();
    n_chk++;
    if (rf_waddr_o !== 5'd0 || ws_allowin_o !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_one_shot got %0d allowin %b want 0 allowin 1",
               rf_waddr_o, ws_allowin_o);
    end
  endtask

  task automatic test_lb_wait();
    step();
    dram_rvalid_i = 1'b0;
    dram_rdata_i  = 32'h80FF_0000;
    drive(5'd7, 1'b1, 32'h0000_1003, 3'd1);
    sb_q.push_back({5'd7, 32'hFFFF_FF80});
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      sample();
      n_chk++;
      if ({ws_allowin_o, fwd_busy_o, rf_waddr_o} !== {1'b0, 1'b1, 5'd0}) begin
        n_fail++;
        $display("FAIL lb_wait%0d got allowin %b busy %b waddr %0d want 0 1 0",
                 i, ws_allowin_o, fwd_busy_o, rf_waddr_o);
      end
      step();
    end
    dram_rvalid_i = 1'b1;
    sample();
    n_chk++;
    if ({rf_waddr_o, rf_wdata_o, ws_allowin_o, fwd_busy_o} !==
        {5'd7, 32'hFFFF_FF80, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL lb_commit got %0d/%h allowin %b busy %b want 7/ffffff80 1 0",
               rf_waddr_o, rf_wdata_o, ws_allowin_o, fwd_busy_o);
    end
    step();
    dram_rvalid_i = 1'b0;
    sample();
    n_chk++;
    if (ws_allowin_o !== 1'b1 || fwd_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_idle got allowin %b fwd_valid %b want 1 0",
               ws_allowin_o, fwd_valid_o);
    end
  endtask

  task automatic test_align_b2b();
    logic [2:0]  t_op  [10] = '{3'd5, 3'd2, 3'd1, 3'd4, 3'd1,
                                3'd2, 3'd2, 3'd3, 3'd6, 3'd3};
    logic [1:0]  t_off [10] = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd0,
                                2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
    logic [31:0] t_word[10] = '{32'hBEEF_1234, 32'hBEEF_1234, 32'h80FF_0000,
                                32'h0000_A500, 32'h0000_007F, 32'h0000_8001,
                                32'hCAFE_BABE, 32'hDEAD_BEEF, 32'h5555_5555,
                                32'h1122_3344};
    logic [31:0] t_exp [10] = '{32'h0000_BEEF, 32'hFFFF_BEEF, 32'hFFFF_FF80,
                                32'h0000_00A5, 32'h0000_007F, 32'hFFFF_8001,
                                32'hCAFE_BABE, 32'hDEAD_BEEF, 32'h0000_0102,
                                32'h1122_3344};
    step();
    dram_rvalid_i = 1'b1;
    drive(5'd1, 1'b1, {30'h40, t_off[0]}, t_op[0]);
    sb_q.push_back({5'd1, t_exp[0]});
    step();
    for (int i = 0; i < 10; i++) begin
      dram_rdata_i = t_word[i];
      if (i + 1 < 10) begin
        drive(5'(i + 2), 1'b1, {30'h40, t_off[i+1]}, t_op[i+1]);
        sb_q.push_back({5'(i + 2), t_exp[i+1]});
      end else begin
        idle();
      end
      sample();
      n_chk++;
      if ({rf_waddr_o, rf_wdata_o, ws_allowin_o} !==
          {5'(i + 1), t_exp[i], 1'b1}) begin
        n_fail++;
        $display("FAIL align%0d got %0d/%h allowin %b want %0d/%h allowin 1",
                 i, rf_waddr_o, rf_wdata_o, ws_allowin_o, i + 1, t_exp[i]);
      end
      step();
    end
    dram_rvalid_i = 1'b0;
  endtask

  task automatic test_dest0();
    drive(5'd0, 1'b1, 32'h0000_0055, 3'd0);
    sb_q.push_back({5'd0, 32'h0000_0055});
    step();
    drive(5'd9, 1'b0, 32'h0000_0066, 3'd0);
    sb_q.push_back({5'd0, 32'h0000_0066});
    sample();
    n_chk++;
    if ({fwd_valid_o, rf_waddr_o, rf_wdata_o} !== {1'b0, 5'd0, 32'h55}) begin
      n_fail++;
      $display("FAIL dest0 got fv %b %0d/%h want 0 0/00000055",
               fwd_valid_o, rf_waddr_o, rf_wdata_o);
    end
    step();
    idle();
    sample();
    n_chk++;
    if ({fwd_valid_o, rf_waddr_o, rf_wdata_o} !== {1'b0, 5'd0, 32'h66}) begin
      n_fail++;
      $display("FAIL no_we got fv %b %0d/%h want 0 0/00000066",
               fwd_valid_o, rf_waddr_o, rf_wdata_o);
    end
  endtask

  task automatic test_flush();
    step();
    dram_rvalid_i = 1'b0;
    drive(5'd4, 1'b1, 32'h0000_0200, 3'd3);
    step();
    idle();
    sample();
    n_chk++;
    if (fwd_busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_busy got %b want 1", fwd_busy_o);
    end
    step();
    flush_i = 1'b1;
    sample();
    step();
    flush_i = 1'b0;
    dram_rvalid_i = 1'b1;
    dram_rdata_i = 32'h1234_5678;
    sample();
    n_chk++;
    if ({fwd_valid_o, rf_waddr_o, rf_wdata_o, ws_allowin_o} !==
        {1'b0, 5'd0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_wait got fv %b %0d/%h allowin %b want 0 0/0 1",
               fwd_valid_o, rf_waddr_o, rf_wdata_o, ws_allowin_o);
    end
    step();
    dram_rvalid_i = 1'b0;
    drive(5'd3, 1'b1, 32'h0000_0033, 3'd0);
    step();
    flush_i = 1'b1;
    drive(5'd10, 1'b1, 32'h0000_0044, 3'd0);
    sample();
    n_chk++;
    if ({rf_waddr_o, rf_wdata_o} !== 37'd0) begin
      n_fail++;
      $display("FAIL flush_commit got %0d/%h want 0/0",
               rf_waddr_o, rf_wdata_o);
    end
    step();
    flush_i = 1'b0;
    idle();
    sample();
    n_chk++;
    if ({fwd_valid_o, rf_waddr_o, rf_wdata_o} !== 38'd0) begin
      n_fail++;
      $display("FAIL flush_drop got fv %b %0d/%h want 0 0/0",
               fwd_valid_o, rf_waddr_o, rf_wdata_o);
    end
  endtask

  task automatic test_rst_wait();
    step();
    dram_rvalid_i = 1'b0;
    drive(5'd6, 1'b1, 32'h0000_0300, 3'd3);
    step();
    idle();
    sample();
    step();
    rst_i = 1'b1;
    sample();
    n_chk++;
    if ({rf_waddr_o, rf_wdata_o, fwd_valid_o, fwd_dest_o, fwd_data_o,
         fwd_busy_o, ws_allowin_o} !== {76'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_wait got %0d %h %b %0d %h %b allowin %b want zeros allowin 1",
               rf_waddr_o, rf_wdata_o, fwd_valid_o, fwd_dest_o,
               fwd_data_o, fwd_busy_o, ws_allowin_o);
    end
    step();
    rst_i = 1'b0;
    dram_rvalid_i = 1'b1;
    dram_rdata_i = 32'hFFFF_0000;
    sample();
    n_chk++;
    if ({fwd_valid_o, rf_waddr_o, rf_wdata_o} !== 38'd0) begin
      n_fail++;
      $display("FAIL rst_drop got fv %b %0d/%h want 0 0/0",
               fwd_valid_o, rf_waddr_o, rf_wdata_o);
    end
    step();
    drive(5'd8, 1'b1, 32'h0000_A5A5, 3'd0);
    sb_q.push_back({5'd8, 32'h0000_A5A5});
    step();
    idle();
    sample();
    n_chk++;
    if ({rf_waddr_o, rf_wdata_o} !== {5'd8, 32'h0000_A5A5}) begin
      n_fail++;
      $display("FAIL rst_recover got %0d/%h want 8/0000a5a5",
               rf_waddr_o, rf_wdata_o);
    end
  endtask

  task automatic test_random();
    logic [2:0]  r_op  [16];
    logic [31:0] r_res [16];
    logic [31:0] r_word[16];
    logic [4:0]  r_dst [16];
    for (int i = 0; i < 16; i++) begin
      r_op[i]   = 3'($urandom_range(0, 7));
      r_res[i]  = $urandom;
      r_word[i] = $urandom;
      r_dst[i]  = 5'($urandom_range(1, 31));
    end
    step();
    dram_rvalid_i = 1'b1;
    drive(r_dst[0], 1'b1, r_res[0], r_op[0]);
    sb_q.push_back({r_dst[0], ref_load(r_op[0], r_res[0], r_word[0])});
    step();
    for (int i = 0; i < 16; i++) begin
      dram_rdata_i = r_word[i];
      if (i + 1 < 16) begin
        drive(r_dst[i+1], 1'b1, r_res[i+1], r_op[i+1]);
        sb_q.push_back({r_dst[i+1],
                        ref_load(r_op[i+1], r_res[i+1], r_word[i+1])});
      end else begin
        idle();
      end
      sample();
      n_chk++;
      if (fwd_data_o !== ref_load(r_op[i], r_res[i], r_word[i])) begin
        n_fail++;
        $display("FAIL rand%0d op %0d fwd_data got %h want %h", i, r_op[i],
                 fwd_data_o, ref_load(r_op[i], r_res[i], r_word[i]));
      end
      step();
    end
    dram_rvalid_i = 1'b0;
  endtask

  task automatic test_drain();
    step();
    sample();
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d pending want 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_wait();
    test_align_b2b();
    test_dest0();
    test_flush();
    test_rst_wait();
    test_random();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
